// File: rtl/sum_fp_sched_pkg.sv
// Shared formats, mode encodings and constant helpers for the shared
// fixed-point adder/quantizer scheduler.
package sum_fp_sched_pkg;

    localparam int NB_IN_A     = 16;
    localparam int NBF_IN_A    = 14;
    localparam int NB_IN_B     = 12;
    localparam int NBF_IN_B    = 11;
    localparam int NB_OUT      = 11;
    localparam int NBF_OUT     = 10;
    localparam int NB_O_ROUND  = 9;
    localparam int NBF_O_ROUND = 8;
    localparam int NB_CNT_DEF  = 16;

    localparam int NBI_A    = NB_IN_A - NBF_IN_A;
    localparam int NBI_B    = NB_IN_B - NBF_IN_B;
    localparam int NBI_O_FR = ((NBI_A > NBI_B) ? NBI_A : NBI_B) + 1;
    localparam int NBF_O_FR = (NBF_IN_A > NBF_IN_B) ? NBF_IN_A : NBF_IN_B;
    localparam int NB_O_FR  = NBI_O_FR + NBF_O_FR;
    localparam int NB_ROUND = NB_O_FR + 1;
    // widths after dropping fractional bits, before the integer part is checked
    localparam int NB_TRUNC = NB_O_FR - (NBF_O_FR - NBF_OUT);
    localparam int NB_RND_T = NB_ROUND - (NBF_O_FR - NBF_O_ROUND);

    typedef enum logic [1:0] {
        MODE_FR         = 2'd0,
        MODE_TRUNC_WRAP = 2'd1,
        MODE_TRUNC_SAT  = 2'd2,
        MODE_ROUND_SAT  = 2'd3
    } mode_t;

    typedef enum logic {
        PTR_CH0 = 1'b0,
        PTR_CH1 = 1'b1
    } ptr_t;

    function automatic logic [NB_O_FR-1:0] max_pos(input int nb);
        logic [NB_O_FR-1:0] v;
        v = '0;
        for (int i = 0; i < NB_O_FR; i++) begin
            v[i] = (i < nb - 1);
        end
        return v;
    endfunction

    function automatic logic [NB_O_FR-1:0] max_neg(input int nb);
        return ~max_pos(nb);
    endfunction

endpackage

// File: rtl/fp_add_quant.sv
// Combinational aligned add of A and B followed by the selected quantization;
// result is the target-format code sign-extended to full-resolution width.
module fp_add_quant
    import sum_fp_sched_pkg::*;
(
    input  logic [NB_IN_A-1:0] a,
    input  logic [NB_IN_B-1:0] b,
    input  logic [1:0]         mode,
    output logic [NB_O_FR-1:0] result,
    output logic               ovf
);
    localparam int SH_A = NBF_O_FR - NBF_IN_A;
    localparam int SH_B = NBF_O_FR - NBF_IN_B;
    localparam logic [NB_O_FR-1:0]  POS_OUT  = max_pos(NB_OUT);
    localparam logic [NB_O_FR-1:0]  NEG_OUT  = max_neg(NB_OUT);
    localparam logic [NB_O_FR-1:0]  POS_RND  = max_pos(NB_O_ROUND);
    localparam logic [NB_O_FR-1:0]  NEG_RND  = max_neg(NB_O_ROUND);
    localparam logic [NB_ROUND-1:0] HALF_LSB = NB_ROUND'(1) << (NBF_O_FR - NBF_O_ROUND - 1);

    logic signed [NB_O_FR-1:0]  a_ext, b_ext, sum_fr;
    logic        [NB_ROUND-1:0] rnd_sum;
    logic        [NB_TRUNC-1:0] tr;
    logic        [NB_RND_T-1:0] rt;
    logic        [NB_O_FR-1:0]  tr_ext, rt_ext;
    logic                       ovf_t, ovf_r, neg;

    assign a_ext   = NB_O_FR'($signed(a)) <<< SH_A;
    assign b_ext   = NB_O_FR'($signed(b)) <<< SH_B;
    assign sum_fr  = a_ext + b_ext;
    assign neg     = sum_fr[NB_O_FR-1];

    assign tr      = sum_fr[NB_O_FR-1 -: NB_TRUNC];
    assign tr_ext  = NB_O_FR'($signed(tr[NB_OUT-1:0]));
    assign ovf_t   = tr[NB_TRUNC-1:NB_OUT-1] != {(NB_TRUNC-NB_OUT+1){tr[NB_OUT-1]}};

    // one extra integer bit so the half-LSB add cannot wrap
    assign rnd_sum = NB_ROUND'(sum_fr) + HALF_LSB;
    assign rt      = rnd_sum[NB_ROUND-1 -: NB_RND_T];
    assign rt_ext  = NB_O_FR'($signed(rt[NB_O_ROUND-1:0]));
    assign ovf_r   = rt[NB_RND_T-1:NB_O_ROUND-1] != {(NB_RND_T-NB_O_ROUND+1){rt[NB_O_ROUND-1]}};

    always_comb begin
        result = sum_fr;
        ovf    = 1'b0;
        case (mode_t'(mode))
            MODE_TRUNC_WRAP: begin
                result = tr_ext;
                ovf    = ovf_t;
            end
            MODE_TRUNC_SAT: begin
                ovf    = ovf_t;
                result = ovf_t ? (neg ? NEG_OUT : POS_OUT) : tr_ext;
            end
            MODE_ROUND_SAT: begin
                ovf    = ovf_r;
                result = ovf_r ? (neg ? NEG_RND : POS_RND) : rt_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sum_fp_sched.sv
// Round-robin scheduler sharing one fp_add_quant between two channels, with a
// registered tagged result and a saturating overflow-event counter.
module sum_fp_sched
    import sum_fp_sched_pkg::*;
#(
    parameter int NB_CNT = NB_CNT_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid0,
    input  logic               i_valid1,
    output logic               o_ready0,
    output logic               o_ready1,
    input  logic [NB_IN_A-1:0] i_a0,
    input  logic [NB_IN_A-1:0] i_a1,
    input  logic [NB_IN_B-1:0] i_b0,
    input  logic [NB_IN_B-1:0] i_b1,
    input  logic [1:0]         i_mode0,
    input  logic [1:0]         i_mode1,
    output logic               o_valid,
    input  logic               i_out_ready,
    output logic [NB_O_FR-1:0] o_result,
    output logic               o_id,
    output logic               o_ovf,
    input  logic               i_clr_cnt,
    output logic [NB_CNT-1:0]  o_ovf_cnt
);
    // state   | meaning
    // PTR_CH0 | ch0 wins when both channels request
    // PTR_CH1 | ch1 wins when both channels request
    ptr_t ptr, ptr_next;

    logic               accept, grant0, grant1, xfer;
    logic [NB_IN_A-1:0] sel_a;
    logic [NB_IN_B-1:0] sel_b;
    logic [1:0]         sel_mode;
    logic [NB_O_FR-1:0] q_result;
    logic               q_ovf;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ptr <= PTR_CH0;
        end else begin
            ptr <= ptr_next;
        end
    end

    always_comb begin
        accept   = ~o_valid | i_out_ready;
        grant0   = i_valid0 & (~i_valid1 | (ptr == PTR_CH0));
        grant1   = i_valid1 & (~i_valid0 | (ptr == PTR_CH1));
        o_ready0 = accept & grant0 & ~i_reset;
        o_ready1 = accept & grant1 & ~i_reset;
        xfer     = o_ready0 | o_ready1;
        ptr_next = ptr;
        if (xfer) begin
            ptr_next = grant1 ? PTR_CH0 : PTR_CH1;
        end
    end

    assign sel_a    = grant1 ? i_a1    : i_a0;
    assign sel_b    = grant1 ? i_b1    : i_b0;
    assign sel_mode = grant1 ? i_mode1 : i_mode0;

    fp_add_quant u_quant (
        .a      (sel_a),
        .b      (sel_b),
        .mode   (sel_mode),
        .result (q_result),
        .ovf    (q_ovf)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_id     <= 1'b0;
            o_ovf    <= 1'b0;
        end else if (accept) begin
            o_valid <= xfer;
            if (xfer) begin
                o_result <= q_result;
                o_id     <= grant1;
                o_ovf    <= q_ovf;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr_cnt) begin
            o_ovf_cnt <= '0;
        end else if (xfer && q_ovf && !(&o_ovf_cnt)) begin
            o_ovf_cnt <= o_ovf_cnt + NB_CNT'(1);
        end
    end

endmodule

// File: tb/tb_sum_fp_sched.sv
// Directed self-checking bench for sum_fp_sched; a second instance with a
// 4-bit counter shares the stimulus so counter saturation is reachable quickly.
module tb_sum_fp_sched;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid0, i_valid1, i_out_ready, i_clr_cnt;
    logic [15:0] i_a0, i_a1;
    logic [11:0] i_b0, i_b1;
    logic [1:0]  i_mode0, i_mode1;
    logic        o_ready0, o_ready1, o_valid, o_id, o_ovf;
    logic [16:0] o_result;
    logic [15:0] o_ovf_cnt;

    logic        s_ready0, s_ready1, s_valid, s_id, s_ovf;
    logic [16:0] s_result;
    logic [3:0]  s_ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clock = ~i_clock;

    sum_fp_sched dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_valid0(i_valid0), .i_valid1(i_valid1),
        .o_ready0(o_ready0), .o_ready1(o_ready1),
        .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1),
        .i_mode0(i_mode0), .i_mode1(i_mode1),
        .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_result(o_result), .o_id(o_id), .o_ovf(o_ovf),
        .i_clr_cnt(i_clr_cnt), .o_ovf_cnt(o_ovf_cnt)
    );

    sum_fp_sched #(.NB_CNT(4)) dut_s (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_valid0(i_valid0), .i_valid1(i_valid1),
        .o_ready0(s_ready0), .o_ready1(s_ready1),
        .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1),
        .i_mode0(i_mode0), .i_mode1(i_mode1),
        .o_valid(s_valid), .i_out_ready(i_out_ready),
        .o_result(s_result), .o_id(s_id), .o_ovf(s_ovf),
        .i_clr_cnt(i_clr_cnt), .o_ovf_cnt(s_ovf_cnt)
    );

    typedef struct packed {
        logic        ch;
        logic [15:0] a;
        logic [11:0] b;
        logic [1:0]  mode;
        logic [16:0] res;
        logic        ovf;
    } vec_t;

    task automatic send(input logic ch, input logic [15:0] a, input logic [11:0] b,
                        input logic [1:0] mode);
        @(negedge i_clock);
        i_valid0 = !ch; i_valid1 = ch;
        i_a0 = a; i_a1 = a; i_b0 = b; i_b1 = b;
        i_mode0 = mode; i_mode1 = mode;
        i_out_ready = 1'b1;
        @(negedge i_clock);
        i_valid0 = 1'b0; i_valid1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clock);
        i_reset = 1'b1; i_valid0 = 1'b1; i_out_ready = 1'b1;
        #1;
        n_checks++;
        if (o_ready0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready0: got %b expected 0", o_ready0);
        end
        @(negedge i_clock);
        i_valid0 = 1'b0;
        n_checks++;
        if ({o_valid, o_result, o_id, o_ovf, o_ovf_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b res=%h id=%b ovf=%b cnt=%h expected all 0",
                     o_valid, o_result, o_id, o_ovf, o_ovf_cnt);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_modes();
        vec_t vecs[14];
        int   exp_cnt = 0;
        vecs = '{
            '{1'b0, 16'h4000, 12'h400, 2'd0, 17'h06000, 1'b0},
            '{1'b0, 16'h4000, 12'h400, 2'd1, 17'h1FE00, 1'b1},
            '{1'b0, 16'h4000, 12'h400, 2'd2, 17'h003FF, 1'b1},
            '{1'b1, 16'h8000, 12'h800, 2'd3, 17'h1FF00, 1'b1},
            '{1'b0, 16'h0020, 12'h000, 2'd3, 17'h00001, 1'b0},
            '{1'b1, 16'h0020, 12'h000, 2'd2, 17'h00002, 1'b0},
            '{1'b0, 16'h0008, 12'h000, 2'd2, 17'h00000, 1'b0},
            '{1'b1, 16'hFFE0, 12'h000, 2'd3, 17'h00000, 1'b0},
            '{1'b0, 16'h8000, 12'h000, 2'd2, 17'h1FC00, 1'b1},
            '{1'b1, 16'h8000, 12'h000, 2'd1, 17'h00000, 1'b1},
            '{1'b0, 16'h7FFF, 12'h3FF, 2'd3, 17'h000FF, 1'b1},
            '{1'b1, 16'hC000, 12'h001, 2'd0, 17'h1C008, 1'b0},
            '{1'b0, 16'h2000, 12'h100, 2'd3, 17'h000A0, 1'b0},
            '{1'b1, 16'hF000, 12'hFFF, 2'd1, 17'h1FEFF, 1'b0}
        };
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].mode);
            exp_cnt += int'(vecs[i].ovf);
            n_checks++;
            if ({o_valid, o_id, o_ovf, o_result} !== {1'b1, vecs[i].ch, vecs[i].ovf, vecs[i].res}) begin
                n_fail++;
                $display("FAIL mode_vec%0d: got valid=%b id=%b ovf=%b res=%h expected valid=1 id=%b ovf=%b res=%h",
                         i, o_valid, o_id, o_ovf, o_result, vecs[i].ch, vecs[i].ovf, vecs[i].res);
            end
            n_checks++;
            if (o_ovf_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL ovf_cnt_vec%0d: got %0d expected %0d", i, o_ovf_cnt, exp_cnt);
            end
        end
        @(negedge i_clock);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_counter_sat();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 16'h4000, 12'h400, 2'd1);
        end
        n_checks++;
        if (s_ovf_cnt !== 4'hF) begin
            n_fail++; $display("FAIL cnt_saturate: got %h expected f", s_ovf_cnt);
        end
        n_checks++;
        if (o_ovf_cnt !== 16'd16) begin
            n_fail++; $display("FAIL cnt_wide: got %0d expected 16", o_ovf_cnt);
        end
        i_clr_cnt = 1'b1;
        send(1'b1, 16'h4000, 12'h400, 2'd2);
        i_clr_cnt = 1'b0;
        n_checks++;
        if ({o_ovf, o_ovf_cnt, s_ovf_cnt} !== {1'b1, 16'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL clr_wins: got ovf=%b cnt=%0d cnt_s=%0d expected ovf=1 cnt=0 cnt_s=0",
                     o_ovf, o_ovf_cnt, s_ovf_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge i_clock);
        i_valid0 = 1'b1; i_valid1 = 1'b1; i_out_ready = 1'b1;
        i_a0 = 16'h0100; i_a1 = 16'h0200; i_b0 = '0; i_b1 = '0;
        i_mode0 = 2'd0; i_mode1 = 2'd0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge i_clock);
                n_checks++;
                if ({o_valid, o_id, o_result} !== {1'b1, ((k - 1) % 2) == 1, ((k - 1) % 2) == 1 ? 17'h00200 : 17'h00100}) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got valid=%b id=%b res=%h expected valid=1 id=%0d",
                             k, o_valid, o_id, o_result, (k - 1) % 2);
                end
            end
            if (k < 4) begin
                #1;
                n_checks++;
                if ({o_ready0, o_ready1} !== ((k % 2) == 0 ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL b2b_grant%0d: got r0=%b r1=%b expected ch%0d", k, o_ready0, o_ready1, k % 2);
                end
            end
        end
        i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({o_ready0, o_ready1, o_valid, o_id, o_result} !== {2'b00, 1'b1, 1'b1, 17'h00200}) begin
                n_fail++;
                $display("FAIL stall%0d: got r0=%b r1=%b valid=%b id=%b res=%h expected 0 0 1 1 00200",
                         k, o_ready0, o_ready1, o_valid, o_id, o_result);
            end
            @(negedge i_clock);
        end
        i_out_ready = 1'b1; i_valid0 = 1'b0; i_valid1 = 1'b0;
        @(negedge i_clock);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge i_clock);
        i_valid0 = 1'b1; i_a0 = 16'h4000; i_b0 = 12'h400; i_mode0 = 2'd0; i_out_ready = 1'b0;
        @(negedge i_clock);
        i_valid0 = 1'b0;
        n_checks++;
        if ({o_valid, o_result} !== {1'b1, 17'h06000}) begin
            n_fail++; $display("FAIL pending: got valid=%b res=%h expected 1 06000", o_valid, o_result);
        end
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        n_checks++;
        if ({o_valid, o_result} !== 18'd0) begin
            n_fail++; $display("FAIL mid_reset: got valid=%b res=%h expected 0 0", o_valid, o_result);
        end
        i_valid0 = 1'b1; i_valid1 = 1'b1;
        #1;
        n_checks++;
        if ({o_ready0, o_ready1} !== 2'b10) begin
            n_fail++; $display("FAIL ptr_after_reset: got r0=%b r1=%b expected 1 0", o_ready0, o_ready1);
        end
        @(negedge i_clock);
        i_valid0 = 1'b0; i_valid1 = 1'b0; i_out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1; i_valid0 = 1'b0; i_valid1 = 1'b0; i_out_ready = 1'b0; i_clr_cnt = 1'b0;
        i_a0 = '0; i_a1 = '0; i_b0 = '0; i_b1 = '0; i_mode0 = '0; i_mode1 = '0;
        test_reset();
        test_modes();
        test_counter_sat();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
